// File: rtl/pixel_write_queue_if.sv
// Pixel write queue bus: pixel strobe input side, framebuffer write side,
// and status. The queue uses the slave modport; its driver uses master.
interface pixel_write_queue_if #(
    parameter int AW = 3
) ();
    logic [23:0] Kbus;
    logic        outEnable;
    logic        fb_valid;
    logic        fb_ready;
    logic [15:0] fb_addr;
    logic [7:0]  fb_data;
    logic [AW:0] count;
    logic        overflow;
    logic        ovf_clr;

    modport slave (
        input  Kbus, outEnable, fb_ready, ovf_clr,
        output fb_valid, fb_addr, fb_data, count, overflow
    );

    modport master (
        output Kbus, outEnable, fb_ready, ovf_clr,
        input  fb_valid, fb_addr, fb_data, count, overflow
    );
endinterface

// File: rtl/pixel_write_queue.sv
// Pixel write queue: captures a pixel on every level change of outEnable
// and presents the queued pixels to the framebuffer with valid/ready.
// Pixels arriving while full (and not draining) are dropped and flagged.
module pixel_write_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pixel_write_queue_if.slave    bus
);
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] colour;
    } pixel_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    pixel_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          en_q, en_d;

    logic          push_evt;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_ok;
    logic          drop;
    pixel_t        head;

    // Decode this cycle's push, pop and drop events
    always_comb begin
        push_evt = (bus.outEnable != en_q);
        full     = (count_q == FULL_COUNT);
        empty    = (count_q == '0);
        // An empty queue ignores fb_ready so count can never underflow.
        pop      = !empty && bus.fb_ready;
        // A full queue still takes a pixel when the head leaves on the same edge.
        push_ok  = push_evt && (!full || pop);
        drop     = push_evt && full && !pop;
    end

    // Next-state for pointers, occupancy, overflow flag and strobe history
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        en_d       = bus.outEnable;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        // Pointers are AW bits wide and DEPTH is 2**AW, so they wrap naturally.
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push_ok, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        // A drop wins over a coincident clear so the loss is never hidden.
        if (drop)             overflow_d = 1'b1;
        else if (bus.ovf_clr) overflow_d = 1'b0;
    end

    // Control state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            en_q       <= en_d;
        end
    end

    // Pixel storage, written at the tail on an accepted push
    // NOTE: storage has no reset; entries are only read while count marks them valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= pixel_t'(bus.Kbus);
    end

    // Head entry and status straight from registered state; no push bypass
    always_comb begin
        head         = mem_q[rd_ptr_q];
        bus.fb_valid = !empty;
        bus.fb_addr  = {head.y, head.x};
        bus.fb_data  = head.colour;
        bus.count    = count_q;
        bus.overflow = overflow_q;
    end
endmodule

// File: tb/tb_pixel_write_queue.sv
// Directed bench for pixel_write_queue: single pixel, backpressure ordering,
// full/drop/overflow, full with simultaneous push and pop, randomised
// interleaving against a queue model, and asynchronous reset mid-stream.
module tb_pixel_write_queue;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    pixel_write_queue_if #(.AW(3)) pwq_if ();

    pixel_write_queue #(.DEPTH(8), .AW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (pwq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a pixel and toggle the strobe, then take one edge
    task automatic push_px(input logic [23:0] px);
        pwq_if.Kbus      = px;
        pwq_if.outEnable = ~pwq_if.outEnable;
        step();
    endtask

    function automatic logic [23:0] mk(input logic [7:0] x);
        return {x, 8'h05, x + 8'h01};
    endfunction

    initial begin
        logic [23:0] model [$];
        logic [23:0] px;
        logic [23:0] hd;
        int          pushes;
        int          cyc;
        logic        do_push;
        logic        do_pop;

        n_tests = 0;
        n_fail  = 0;
        rst_n            = 1'b0;
        pwq_if.Kbus      = '0;
        pwq_if.outEnable = 1'b0;
        pwq_if.fb_ready  = 1'b0;
        pwq_if.ovf_clr   = 1'b0;
        step();
        step();
        check("rst_valid", 32'(pwq_if.fb_valid), 0);
        check("rst_count", 32'(pwq_if.count), 0);
        check("rst_ovf", 32'(pwq_if.overflow), 0);
        rst_n = 1'b1;
        step();

        // Single pixel
        pwq_if.fb_ready = 1'b1;
        push_px(24'h12_34_07);
        check("single_valid", 32'(pwq_if.fb_valid), 1);
        check("single_addr", 32'(pwq_if.fb_addr), 32'h3412);
        check("single_data", 32'(pwq_if.fb_data), 32'h07);
        check("single_count", 32'(pwq_if.count), 1);
        step();
        check("single_done_valid", 32'(pwq_if.fb_valid), 0);
        check("single_done_count", 32'(pwq_if.count), 0);

        // Backpressure and order
        pwq_if.fb_ready = 1'b0;
        push_px(mk(8'd1));
        push_px(mk(8'd2));
        push_px(mk(8'd3));
        check("bp_count", 32'(pwq_if.count), 3);
        check("bp_head", 32'(pwq_if.fb_addr), 32'h0501);
        step();
        check("bp_hold_addr", 32'(pwq_if.fb_addr), 32'h0501);
        check("bp_hold_data", 32'(pwq_if.fb_data), 32'h02);
        pwq_if.fb_ready = 1'b1;
        step();
        check("bp_x2", 32'(pwq_if.fb_addr), 32'h0502);
        check("bp_cnt2", 32'(pwq_if.count), 2);
        step();
        check("bp_x3", 32'(pwq_if.fb_addr), 32'h0503);
        check("bp_cnt1", 32'(pwq_if.count), 1);
        step();
        check("bp_empty", 32'(pwq_if.fb_valid), 0);

        // Full and drop
        pwq_if.fb_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_px(mk(8'h10 + 8'(i)));
        check("full_count", 32'(pwq_if.count), 8);
        check("full_no_ovf", 32'(pwq_if.overflow), 0);
        push_px(mk(8'h18));
        check("drop_count", 32'(pwq_if.count), 8);
        check("drop_ovf", 32'(pwq_if.overflow), 1);
        pwq_if.fb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_addr", 32'(pwq_if.fb_addr), 32'(16'h0500 | 16'(8'h10 + 8'(i))));
            step();
        end
        check("drain_valid", 32'(pwq_if.fb_valid), 0);
        check("drain_count", 32'(pwq_if.count), 0);
        check("ovf_sticky", 32'(pwq_if.overflow), 1);
        pwq_if.ovf_clr = 1'b1;
        step();
        pwq_if.ovf_clr = 1'b0;
        check("ovf_cleared", 32'(pwq_if.overflow), 0);

        // Drop coinciding with clear keeps overflow set
        pwq_if.fb_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_px(mk(8'h20 + 8'(i)));
        pwq_if.ovf_clr = 1'b1;
        push_px(mk(8'h99));
        check("drop_clr_ovf", 32'(pwq_if.overflow), 1);
        check("drop_clr_count", 32'(pwq_if.count), 8);
        step();
        pwq_if.ovf_clr = 1'b0;
        check("clr_after", 32'(pwq_if.overflow), 0);

        // Full with simultaneous push and pop
        pwq_if.fb_ready = 1'b1;
        push_px(mk(8'h28));
        check("fullpp_count", 32'(pwq_if.count), 8);
        check("fullpp_ovf", 32'(pwq_if.overflow), 0);
        for (int i = 1; i <= 8; i++) begin
            check("fullpp_order", 32'(pwq_if.fb_addr), 32'(16'h0500 | 16'(8'h20 + 8'(i))));
            step();
        end
        check("fullpp_empty", 32'(pwq_if.count), 0);

        // Randomised interleaving against a queue model (wraps pointers)
        pushes = 0;
        cyc    = 0;
        while (pushes < 20 && cyc < 200) begin
            do_push = 1'($urandom_range(0, 1));
            pwq_if.fb_ready = 1'($urandom_range(0, 1));
            check("rnd_valid", 32'(pwq_if.fb_valid), 32'(model.size() != 0));
            if (model.size() != 0) begin
                hd = model[0];
                check("rnd_head", 32'(pwq_if.fb_addr), 32'({hd[15:8], hd[23:16]}));
            end
            do_pop = (model.size() != 0) && pwq_if.fb_ready;
            px = 24'($urandom);
            if (do_pop) void'(model.pop_front());
            if (do_push) begin
                pushes++;
                if (model.size() < 8) model.push_back(px);
                pwq_if.Kbus      = px;
                pwq_if.outEnable = ~pwq_if.outEnable;
            end
            step();
            check("rnd_count", 32'(pwq_if.count), 32'(model.size()));
            cyc++;
        end
        check("rnd_budget", 32'(pushes), 20);
        pwq_if.fb_ready = 1'b1;
        cyc = 0;
        while (model.size() != 0 && cyc < 20) begin
            hd = model.pop_front();
            check("rnd_drain", 32'(pwq_if.fb_addr), 32'({hd[15:8], hd[23:16]}));
            step();
            cyc++;
        end
        check("rnd_final_count", 32'(pwq_if.count), 0);

        // Reset mid-stream
        pwq_if.fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_px(mk(8'h40 + 8'(i)));
        check("mid_count", 32'(pwq_if.count), 5);
        #2;
        rst_n = 1'b0;
        pwq_if.outEnable = 1'b0;
        #1;
        check("mid_rst_valid", 32'(pwq_if.fb_valid), 0);
        check("mid_rst_count", 32'(pwq_if.count), 0);
        #1;
        rst_n = 1'b1;
        step();
        check("post_rst_count", 32'(pwq_if.count), 0);
        pwq_if.fb_ready = 1'b1;
        push_px(24'h55_66_77);
        check("post_valid", 32'(pwq_if.fb_valid), 1);
        check("post_addr", 32'(pwq_if.fb_addr), 32'h6655);
        check("post_data", 32'(pwq_if.fb_data), 32'h77);
        step();
        check("post_one_write", 32'(pwq_if.fb_valid), 0);
        step();
        check("post_idle", 32'(pwq_if.count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
